// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI frame slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } spi_state_t;

  // Bit counter must hold the larger frame length itself, not just length-1.
  function automatic int cnt_width(input int in_w, input int out_w);
    int m;
    m = (in_w > out_w) ? in_w : out_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises sck/sdi/cs_n into clk and decodes registered edge strobes.
// All outputs are registered, so every strobe appears SYNC_STAGES+1 clk
// after the pin edge; sdi_q is aligned with sample_edge.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic sdi,
  input  logic cs_n,
  output logic sdi_q,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync;
  logic sck_d, cs_d;
  logic sck_now, sdi_now, cs_now;
  logic lead, trail;

  assign sck_now = sck_sync[SYNC_STAGES-1];
  assign sdi_now = sdi_sync[SYNC_STAGES-1];
  assign cs_now  = cs_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead  = CPOL ? (sck_d & ~sck_now) : (~sck_d & sck_now);
  assign trail = CPOL ? (~sck_d & sck_now) : (sck_d & ~sck_now);

  // Synchroniser chains, one-cycle history and registered edge decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync    <= {SYNC_STAGES{CPOL}};
      sdi_sync    <= '0;
      cs_sync     <= '1;
      sck_d       <= CPOL;
      cs_d        <= 1'b1;
      sdi_q       <= 1'b0;
      sample_edge <= 1'b0;
      shift_edge  <= 1'b0;
      cs_fall     <= 1'b0;
      cs_rise     <= 1'b0;
    end else begin
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_d       <= sck_now;
      cs_d        <= cs_now;
      sdi_q       <= sdi_now;
      // sck activity outside a selected frame is ignored.
      sample_edge <= ~cs_now & (CPHA ? trail : lead);
      shift_edge  <= ~cs_now & (CPHA ? lead : trail);
      cs_fall     <= cs_d & ~cs_now;
      cs_rise     <= ~cs_d & cs_now;
    end
  end

endmodule

// File: rtl/spi_frame_slave.sv
// System-clock SPI slave: receives one IN_W-bit request per frame and
// returns a captured OUT_W-bit response on a later frame, MSB first.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int IN_W        = 256,
  parameter int OUT_W       = 128,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             sdi,
  input  logic             cs_n,
  output logic             sdo,
  output logic [IN_W-1:0]  rx_data,
  output logic             rx_valid,
  input  logic [OUT_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             frame_err
);

  localparam int CNT_W = cnt_width(IN_W, OUT_W);
  localparam logic [CNT_W-1:0] IN_MAX  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(OUT_W);

  logic             sdi_q, sample_edge, shift_edge, cs_fall, cs_rise;
  spi_state_t       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [IN_W-1:0]  rx_shift;
  logic [OUT_W-1:0] tx_shift, tx_buf;
  logic             tx_full, lead_seen, accept;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (CPOL),
    .CPHA       (CPHA)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sck        (sck),
    .sdi        (sdi),
    .cs_n       (cs_n),
    .sdi_q      (sdi_q),
    .sample_edge(sample_edge),
    .shift_edge (shift_edge),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  // The response buffer is never overwritten while it is being shifted out.
  assign accept = tx_valid && tx_ready && (state != TX);

  // Frame FSM, shift registers and response handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_shift  <= '0;
      tx_buf    <= '0;
      tx_full   <= 1'b0;
      tx_ready  <= 1'b1;
      sdo       <= 1'b0;
      frame_err <= 1'b0;
      lead_seen <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // tx_buf keeps a pristine copy so a short readout can be retried.
      if (accept) begin
        tx_buf   <= tx_data;
        tx_shift <= tx_data;
        sdo      <= tx_data[OUT_W-1];
        tx_full  <= 1'b1;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Decided on tx_full before any same-cycle accept lands.
          if (cs_fall) begin
            state     <= tx_full ? TX : RX;
            bit_cnt   <= '0;
            lead_seen <= 1'b0;
          end
        end
        RX: begin
          if (sample_edge) begin
            rx_shift <= {rx_shift[IN_W-2:0], sdi_q};
            if (bit_cnt != IN_MAX) bit_cnt <= bit_cnt + 1'b1;
          end
          if (cs_rise) begin
            if (bit_cnt == IN_MAX) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        TX: begin
          // sdi is still clocked by the master; only the bit count matters.
          if (sample_edge && bit_cnt != OUT_MAX) bit_cnt <= bit_cnt + 1'b1;
          if (shift_edge) begin
            // With CPHA=1 the first leading edge presents the MSB already on sdo.
            if (CPHA && !lead_seen) begin
              lead_seen <= 1'b1;
            end else begin
              tx_shift <= tx_shift << 1;
              sdo      <= tx_shift[OUT_W-2];
            end
          end
          if (cs_rise) begin
            state <= IDLE;
            if (bit_cnt == OUT_MAX) begin
              tx_full  <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              tx_shift  <= tx_buf;
              sdo       <= tx_buf[OUT_W-1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
